// File: rtl/cdf_pipeline.sv
// Histogram equalizer stage 2: reads 256 bins from m2, writes the saturating
// inclusive CDF to m3, optionally clears m2, and reports min/total of the pass.
module cdf_pipeline #(
  parameter int BINS       = 256,
  parameter int CNT_W      = 32,
  parameter int HIST_BASE  = 0,
  parameter int CDF_BASE   = 0,
  parameter int CLEAR_HIST = 1
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] m2ReadVal,
  output logic [15:0]  m2ReadAddr,
  output logic [15:0]  m2WriteAddr,
  output logic [127:0] m2WriteVal,
  output logic         m2WE,
  output logic [15:0]  m3WriteAddr,
  output logic [127:0] m3WriteVal,
  output logic         m3WE,
  output logic [31:0]  cdfMin,
  output logic [31:0]  cdfTotal,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [15:0]      k_r;
  logic             iss_vld_r;
  logic             dat_vld_r;
  logic [15:0]      dat_bin_r;
  logic [CNT_W-1:0] acc_r;
  logic [CNT_W-1:0] min_r;
  logic             min_found_r;

  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W:0]   sum_s;
  logic [CNT_W-1:0] acc_next_s;
  logic             unused_s;

  assign unused_s = ^m2ReadVal[127:CNT_W];

  // Saturating accumulate of the bin count arriving this cycle.
  always_comb begin
    cnt_s = m2ReadVal[CNT_W-1:0];
    sum_s = {1'b0, acc_r} + {1'b0, cnt_s};
    if (sum_s[CNT_W]) begin
      acc_next_s = {CNT_W{1'b1}};
    end else begin
      acc_next_s = sum_s[CNT_W-1:0];
    end
  end

  // Control FSM, read-address issue and the registered write/result datapath.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= 16'd0;
      iss_vld_r   <= 1'b0;
      dat_vld_r   <= 1'b0;
      dat_bin_r   <= 16'd0;
      acc_r       <= {CNT_W{1'b0}};
      min_r       <= {CNT_W{1'b0}};
      min_found_r <= 1'b0;
      m2ReadAddr  <= 16'd0;
      m2WriteAddr <= 16'd0;
      m2WriteVal  <= 128'd0;
      m2WE        <= 1'b0;
      m3WriteAddr <= 16'd0;
      m3WriteVal  <= 128'd0;
      m3WE        <= 1'b0;
      cdfMin      <= 32'd0;
      cdfTotal    <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      m2WE       <= 1'b0;
      m3WE       <= 1'b0;
      m2WriteVal <= 128'd0;
      done       <= 1'b0;
      // Data for the address issued one cycle earlier is valid now.
      dat_vld_r  <= iss_vld_r;
      dat_bin_r  <= k_r;

      if (dat_vld_r) begin
        acc_r       <= acc_next_s;
        m3WE        <= 1'b1;
        m3WriteAddr <= 16'(CDF_BASE) + dat_bin_r;
        m3WriteVal  <= 128'(acc_next_s);
        if (CLEAR_HIST != 0) begin
          m2WE        <= 1'b1;
          m2WriteAddr <= 16'(HIST_BASE) + dat_bin_r;
        end
        if (!min_found_r && (acc_next_s != {CNT_W{1'b0}})) begin
          min_r       <= acc_next_s;
          min_found_r <= 1'b1;
        end
        // Results are published only once the final bin is in.
        if (dat_bin_r == 16'(BINS - 1)) begin
          cdfTotal <= 32'(acc_next_s);
          cdfMin   <= min_found_r ? 32'(min_r) : 32'(acc_next_s);
        end
      end

      case (state_r)
        IDLE: begin
          busy      <= start;
          iss_vld_r <= start;
          if (start) begin
            state_r     <= READ;
            k_r         <= 16'd0;
            m2ReadAddr  <= 16'(HIST_BASE);
            acc_r       <= {CNT_W{1'b0}};
            min_r       <= {CNT_W{1'b0}};
            min_found_r <= 1'b0;
          end
        end
        READ: begin
          busy <= 1'b1;
          if (k_r == 16'(BINS - 1)) begin
            state_r   <= DRAIN;
            iss_vld_r <= 1'b0;
          end else begin
            k_r        <= k_r + 16'd1;
            m2ReadAddr <= 16'(HIST_BASE) + k_r + 16'd1;
            iss_vld_r  <= 1'b1;
          end
        end
        DRAIN: begin
          state_r   <= DONE;
          busy      <= 1'b0;
          iss_vld_r <= 1'b0;
        end
        DONE: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          iss_vld_r <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          iss_vld_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_pipeline.sv
// Scoreboard bench for cdf_pipeline: stimulus pushes expected CDF writes and
// pass results into queues; a negedge monitor pops and compares them.
module tb_cdf_pipeline;

  logic         clock = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] m2ReadVal;
  logic [15:0]  m2ReadAddr, m2WriteAddr, m3WriteAddr;
  logic [127:0] m2WriteVal, m3WriteVal;
  logic         m2WE, m3WE, busy, done;
  logic [31:0]  cdfMin, cdfTotal;

  typedef struct {
    int          addr;
    logic [31:0] val;
  } wr_t;

  typedef struct {
    longint      cyc;
    logic [31:0] mn;
    logic [31:0] tot;
  } sum_t;

  wr_t         exp_q[$];
  sum_t        sum_q[$];
  logic [31:0] hist_tb[256];
  logic [31:0] m2_mem[256];
  logic        load_en;
  longint      cyc = 0;
  logic        rst_seen = 1'b1;
  int          clear_req = 0;
  int          clear_ack = 0;
  int          total = 0;
  int          bad = 0;

  cdf_pipeline dut (
    .clock(clock), .rst(rst), .start(start), .m2ReadVal(m2ReadVal),
    .m2ReadAddr(m2ReadAddr), .m2WriteAddr(m2WriteAddr), .m2WriteVal(m2WriteVal),
    .m2WE(m2WE), .m3WriteAddr(m3WriteAddr), .m3WriteVal(m3WriteVal), .m3WE(m3WE),
    .cdfMin(cdfMin), .cdfTotal(cdfTotal), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // m2 scratchpad: 1-cycle read latency, random junk in the ignored upper bits.
  always @(posedge clock) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) m2_mem[i] <= hist_tb[i];
    end else if (m2WE) begin
      m2_mem[m2WriteAddr[7:0]] <= m2WriteVal[31:0];
    end
    m2ReadVal <= {$urandom, $urandom, $urandom, m2_mem[m2ReadAddr[7:0]]};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clock) begin
    if (rst_seen) begin
      exp_q.delete();
      sum_q.delete();
      chk("rst_ctrl", {m2ReadAddr, m2WriteAddr, m2WE, m3WriteAddr, m3WE,
                       cdfMin, cdfTotal, busy, done}, 128'd0);
      chk("rst_data", m2WriteVal | m3WriteVal, 128'd0);
    end else begin
      if (m3WE) begin
        if (exp_q.size() == 0) begin
          chk("m3_unexpected_write", {112'd0, m3WriteAddr}, 128'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("m3_addr", {112'd0, m3WriteAddr}, 128'(e.addr));
          chk("m3_val", m3WriteVal, {96'd0, e.val});
          chk("m2_clear_we", {127'd0, m2WE}, 128'd1);
          chk("m2_clear_addr", {112'd0, m2WriteAddr}, 128'(e.addr));
          chk("m2_clear_val", m2WriteVal, 128'd0);
        end
      end
      if (done) begin
        if (sum_q.size() == 0) begin
          chk("done_unexpected", {127'd0, done}, 128'd0);
        end else begin
          sum_t s;
          s = sum_q.pop_front();
          chk("done_cycle", 128'(cyc), 128'(s.cyc));
          chk("cdfMin", {96'd0, cdfMin}, {96'd0, s.mn});
          chk("cdfTotal", {96'd0, cdfTotal}, {96'd0, s.tot});
          chk("writes_left_at_done", 128'(exp_q.size()), 128'd0);
          chk("busy_at_done", {127'd0, busy}, 128'd0);
        end
      end else if (sum_q.size() != 0 && cyc > sum_q[0].cyc + 3) begin
        chk("done_timeout", {127'd0, done}, 128'd1);
        void'(sum_q.pop_front());
      end
      if (clear_req != clear_ack) begin
        int nz;
        nz = 0;
        for (int i = 0; i < 256; i++) if (m2_mem[i] != 32'd0) nz++;
        chk("m2_nonzero_bins_after_done", 128'(nz), 128'd0);
        clear_ack = clear_req;
      end
    end
  end

  // Reference model: inclusive prefix sum clamped to 32 bits, first non-zero value.
  task automatic run_pass(input bit do_reset, input bit repulse);
    longint      s;
    logic [31:0] mn;
    @(negedge clock);
    load_en = 1'b1;
    @(negedge clock);
    load_en = 1'b0;
    s  = 0;
    mn = 32'd0;
    for (int k = 0; k < 256; k++) begin
      s = s + longint'(hist_tb[k]);
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
      exp_q.push_back('{k, s[31:0]});
      if (mn == 32'd0 && s != 0) mn = s[31:0];
    end
    sum_q.push_back('{cyc + 259, mn, s[31:0]});
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (do_reset) begin
      repeat (51) @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
    end
    if (repulse) begin
      repeat (99) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    for (int t = 0; t < 400 && sum_q.size() != 0; t++) @(negedge clock);
    repeat (6) @(negedge clock);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    load_en = 1'b0;
    for (int i = 0; i < 256; i++) hist_tb[i] = 32'd0;
    repeat (3) @(negedge clock);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) hist_tb[i] = 32'd1;
    run_pass(1'b0, 1'b0);

    for (int i = 0; i < 256; i++) hist_tb[i] = 32'd0;
    hist_tb[100] = 32'd4096;
    run_pass(1'b0, 1'b0);

    for (int i = 0; i < 256; i++) hist_tb[i] = 32'd0;
    run_pass(1'b0, 1'b0);

    hist_tb[0] = 32'hFFFF_FFF0;
    hist_tb[1] = 32'h0000_0100;
    run_pass(1'b0, 1'b0);

    for (int i = 0; i < 256; i++)
      hist_tb[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
    run_pass(1'b0, 1'b1);
    clear_req++;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 256; i++) hist_tb[i] = 32'($urandom_range(0, 100000));
    run_pass(1'b1, 1'b0);

    for (int i = 0; i < 256; i++)
      hist_tb[i] = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom);
    run_pass(1'b0, 1'b0);
    clear_req++;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
